x_bist_seq: RTL and testbench
=============================

# x_bist_seq

Built-in self-test sequencer for the 16-device 23K640 SRAM array. On a start pulse it takes over one selected device's valid/accept/ready channel and runs a fixed sequence: a write pass over the whole address range, then a read-and-compare pass. It counts mismatches and read timeouts, and holds the results for the tester-side logic to read back. It drives the same shared `rd_n_wr`/`addr`/`wdata` bus and per-device valid vector as the tester-command driver, and is muxed against it at the top level.

## Interface
Parameters:
- `p_last`, default 16'h1FFF: last address tested. The range is 0..`p_last` inclusive; 8 KB device.
- `p_timeout`, default 255: maximum cycles to wait for `ready` after a read is accepted.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_start`, in, 1: start pulse. Sampled only in IDLE or DONE.
- `i_sel`, in, 4: device under test. Latched on start.
- `i_seed`, in, 8: pattern seed. Latched on start.
- `i_abort`, in, 1: abort request.
- `o_valid`, out, 16: request valid, one-hot at the selected device.
- `i_accept`, in, 16: per-device request accepted.
- `i_ready`, in, 16: per-device read data available.
- `i_rdata`, in, 128: read data. Device n occupies bits [8n+7:8n].
- `o_rd_n_wr`, out, 1: 1 = read, 0 = write.
- `o_addr`, out, 16: request address.
- `o_wdata`, out, 8: write data.
- `o_busy`, out, 1: state is not IDLE and not DONE.
- `o_done`, out, 1: a run has completed. Held until the next start.
- `o_pass`, out, 1: meaningful only when `o_done` is high. Equals `err_cnt == 0` and no timeout.
- `o_err_cnt`, out, 16: number of data mismatches. Saturates at 16'hFFFF.
- `o_first_err_addr`, out, 16: address of the first mismatch. 0 if there was none.
- `o_timeout`, out, 1: the run ended on a read timeout.

## Operation
- All outputs are registered. Reset value of every output is 0.
- States:
  - IDLE → WR on `i_start`. Latch `sel` and `seed`, clear `addr`, the counters and all result outputs.
  - WR:
    - Drive `o_valid = 1<<sel`, `o_rd_n_wr = 0`, `o_wdata = seed ^ addr[7:0]`.
    - On `i_accept[sel]`:
      - If `addr == p_last`: set `addr = 0` and go to RD.
      - Otherwise: increment `addr`.
    - A write is complete on accept. `ready` is not expected for writes.
  - RD:
    - Drive `o_valid = 1<<sel`, `o_rd_n_wr = 1`.
    - On `i_accept[sel]`: go to RD_WAIT and clear the timeout counter.
    - If `i_ready[sel]` arrives in the same cycle as accept, treat it as RD_WAIT completion directly.
  - RD_WAIT:
    - `o_valid = 0`. The timeout counter increments each cycle.
    - On `i_ready[sel]`, compare `i_rdata[sel]` against `seed ^ addr[7:0]`:
      - On mismatch, increment `err_cnt` (saturating).
      - Record `addr` into `o_first_err_addr` if this is the first mismatch.
    - Then, if `addr == p_last`, go to DONE; otherwise increment `addr` and go to RD.
    - If the counter reaches `p_timeout` with no ready: set `o_timeout` and go to DONE.
  - DONE:
    - `o_done = 1`, `o_valid = 0`; results are held.
    - `i_start` begins a new run. `o_done` clears in that cycle's next state.
- Channel selection:
  - Only `i_accept[sel]` and `i_ready[sel]` are observed. Other bits are ignored.
  - `o_valid` bits other than `sel` are always 0.
- Handshake rules:
  - Once `o_valid` is raised, it and `o_rd_n_wr`, `o_addr` and `o_wdata` stay stable until accept is sampled.
- Abort:
  - `i_abort` is latched as a pending flag.
  - The flag is honoured only at a request boundary: in WR/RD when no valid is outstanding or on the accept cycle of a write, or on ready/timeout in RD_WAIT.
  - Honouring it goes to IDLE with `o_done = 0`. A valid is never dropped before accept.
  - Abort in IDLE or DONE has no effect.
- `i_start` while busy is ignored.
- `o_addr = {3'b0, addr[12:0]}` when `p_last` is the default value. In general `addr` is 16 bits wide and wraps only via the `p_last` compare.
- Reset mid-run:
  - All state and outputs return to 0 immediately.
  - The device may be left with an unaccepted request. The top level is responsible for resetting the drivers together.

## Timing
- Start sampled at cycle 0 → `o_valid`/`o_addr = 0`/`o_wdata = seed` at cycle 1.
- Writes are back-to-back: accept in cycle n → next address presented in cycle n+1 with valid still high. With accept every cycle, a write takes 1 cycle per address.
- Reads:
  - Accept in cycle n → `o_valid` low in cycle n+1.
  - Ready in cycle m → next read valid in cycle m+1.
  - Ready on the final address in cycle m → `o_done` in cycle m+1.
- Timeout: `o_timeout`/`o_done` assert `p_timeout`+1 cycles after the accept cycle.
- `o_pass`, `o_err_cnt` and `o_first_err_addr` are final in the same cycle `o_done` rises.

## Test plan
- Fault-free model, `p_last=3`, `seed=0xA5`, `sel=2`:
  - Writes go to addr 0..3 with data A5, A4, A7, A6. `o_valid = 16'h0004` throughout.
  - Reads compare clean.
  - Result: `o_done=1`, `o_pass=1`, `err_cnt=0`, `first_err_addr=0`.
- Same setup, but the model returns 0x00 at addr 2 and 0xFF at addr 3:
  - Result: `err_cnt=2`, `first_err_addr=2`, `o_pass=0`.
- Model withholds ready for the read of addr 1, with `p_timeout=16`:
  - `o_timeout` and `o_done` rise 17 cycles after that accept.
  - `o_pass=0`. No further requests are issued.
- Accept held off 5 cycles on a write and on a read:
  - `o_valid`, `o_addr`, `o_wdata` and `o_rd_n_wr` stay stable for all 5 cycles.
  - Accept and ready in the same cycle advances to the next read in the following cycle.
- `sel=0xF`:
  - `o_valid = 16'h8000`.
  - `accept`/`ready` pulses on bit 0 are ignored and the block stalls.
  - `i_start` pulsed mid-run changes nothing.
- Abort during RD_WAIT: IDLE is reached only after ready, with `o_done=0`. Separately, asserting `i_rst` mid-write clears every output to 0 asynchronously.

Source files
------------

// File: rtl/x_bist_seq.sv
// Built-in self-test sequencer for one device of the 23K640 SRAM array:
// a full write pass followed by a read-and-compare pass over 0..p_last.
module x_bist_seq #(
   parameter logic [15:0] p_last    = 16'h1FFF,
   parameter int          p_timeout = 255
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [3:0]   i_sel,
   input  logic [7:0]   i_seed,
   input  logic         i_abort,
   output logic [15:0]  o_valid,
   input  logic [15:0]  i_accept,
   input  logic [15:0]  i_ready,
   input  logic [127:0] i_rdata,
   output logic         o_rd_n_wr,
   output logic [15:0]  o_addr,
   output logic [7:0]   o_wdata,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_pass,
   output logic [15:0]  o_err_cnt,
   output logic [15:0]  o_first_err_addr,
   output logic         o_timeout
);

   localparam int cnt_w = (p_timeout > 2) ? $clog2(p_timeout) : 1;
   localparam logic [cnt_w-1:0] t_last = cnt_w'(p_timeout - 1);

   typedef enum logic [2:0] {
      s_idle,
      s_wr,
      s_rd,
      s_rd_wait,
      s_done
   } state_t;

   state_t            state_q, state_nx;
   logic [3:0]        sel_q, sel_nx;
   logic [7:0]        seed_q, seed_nx;
   logic [15:0]       addr_q, addr_nx;
   logic [15:0]       valid_q, valid_nx;
   logic              rd_n_wr_q, rd_n_wr_nx;
   logic [7:0]        wdata_q, wdata_nx;
   logic              busy_q, busy_nx;
   logic              done_q, done_nx;
   logic              pass_q, pass_nx;
   logic [15:0]       err_q, err_nx;
   logic [15:0]       first_q, first_nx;
   logic              timeout_q, timeout_nx;
   logic [cnt_w-1:0]  tcnt_q, tcnt_nx;
   logic              abort_q, abort_nx;

   logic        acc, rdy, abort_eff, last, mismatch, complete, to_idle;
   logic [7:0]  rd_byte;
   logic [15:0] addr_inc, err_inc;

   assign acc       = i_accept[sel_q];
   assign rdy       = i_ready[sel_q];
   assign rd_byte   = i_rdata[{sel_q, 3'b000} +: 8];
   assign mismatch  = rd_byte != (seed_q ^ addr_q[7:0]);
   assign last      = addr_q == p_last;
   assign addr_inc  = addr_q + 16'd1;
   assign err_inc   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
   assign abort_eff = abort_q | i_abort;

   always_comb begin
      state_nx   = state_q;
      sel_nx     = sel_q;
      seed_nx    = seed_q;
      addr_nx    = addr_q;
      valid_nx   = valid_q;
      rd_n_wr_nx = rd_n_wr_q;
      wdata_nx   = wdata_q;
      busy_nx    = busy_q;
      done_nx    = done_q;
      pass_nx    = pass_q;
      err_nx     = err_q;
      first_nx   = first_q;
      timeout_nx = timeout_q;
      tcnt_nx    = tcnt_q;
      abort_nx   = abort_q;
      complete   = 1'b0;
      to_idle    = 1'b0;

      case (state_q)
         s_idle, s_done: begin
            if (i_start) begin
               state_nx   = s_wr;
               sel_nx     = i_sel;
               seed_nx    = i_seed;
               addr_nx    = 16'd0;
               valid_nx   = 16'd1 << i_sel;
               rd_n_wr_nx = 1'b0;
               wdata_nx   = i_seed;
               busy_nx    = 1'b1;
               done_nx    = 1'b0;
               pass_nx    = 1'b0;
               err_nx     = 16'd0;
               first_nx   = 16'd0;
               timeout_nx = 1'b0;
               tcnt_nx    = '0;
               abort_nx   = 1'b0;
            end
         end
         s_wr: begin
            abort_nx = abort_eff;
            if (acc) begin
               if (abort_eff) begin
                  to_idle = 1'b1;
               end else if (last) begin
                  state_nx   = s_rd;
                  addr_nx    = 16'd0;
                  rd_n_wr_nx = 1'b1;
                  wdata_nx   = seed_q;
               end else begin
                  addr_nx  = addr_inc;
                  wdata_nx = seed_q ^ addr_inc[7:0];
               end
            end
         end
         s_rd: begin
            abort_nx = abort_eff;
            if (acc) begin
               if (rdy) begin
                  complete = 1'b1;
               end else begin
                  state_nx = s_rd_wait;
                  valid_nx = 16'd0;
                  tcnt_nx  = '0;
               end
            end
         end
         s_rd_wait: begin
            abort_nx = abort_eff;
            tcnt_nx  = tcnt_q + cnt_w'(1);
            if (rdy) begin
               complete = 1'b1;
            end else if (tcnt_q == t_last) begin
               timeout_nx = 1'b1;
               pass_nx    = 1'b0;
               if (abort_eff) begin
                  to_idle = 1'b1;
               end else begin
                  state_nx = s_done;
                  done_nx  = 1'b1;
                  busy_nx  = 1'b0;
                  valid_nx = 16'd0;
               end
            end
         end
         default: state_nx = s_idle;
      endcase

      // A read completes either in RD (accept with ready) or in RD_WAIT.
      if (complete) begin
         if (mismatch) begin
            err_nx = err_inc;
            if (err_q == 16'd0) first_nx = addr_q;
         end
         if (abort_eff) begin
            to_idle = 1'b1;
         end else if (last) begin
            state_nx = s_done;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            valid_nx = 16'd0;
            pass_nx  = !mismatch && (err_q == 16'd0) && !timeout_q;
         end else begin
            state_nx   = s_rd;
            addr_nx    = addr_inc;
            valid_nx   = 16'd1 << sel_q;
            rd_n_wr_nx = 1'b1;
            wdata_nx   = seed_q ^ addr_inc[7:0];
         end
      end

      if (to_idle) begin
         state_nx = s_idle;
         valid_nx = 16'd0;
         busy_nx  = 1'b0;
         done_nx  = 1'b0;
         pass_nx  = 1'b0;
         abort_nx = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= s_idle;
         sel_q     <= 4'd0;
         seed_q    <= 8'd0;
         addr_q    <= 16'd0;
         valid_q   <= 16'd0;
         rd_n_wr_q <= 1'b0;
         wdata_q   <= 8'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= 16'd0;
         first_q   <= 16'd0;
         timeout_q <= 1'b0;
         tcnt_q    <= '0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_nx;
         sel_q     <= sel_nx;
         seed_q    <= seed_nx;
         addr_q    <= addr_nx;
         valid_q   <= valid_nx;
         rd_n_wr_q <= rd_n_wr_nx;
         wdata_q   <= wdata_nx;
         busy_q    <= busy_nx;
         done_q    <= done_nx;
         pass_q    <= pass_nx;
         err_q     <= err_nx;
         first_q   <= first_nx;
         timeout_q <= timeout_nx;
         tcnt_q    <= tcnt_nx;
         abort_q   <= abort_nx;
      end
   end

   assign o_valid          = valid_q;
   assign o_rd_n_wr        = rd_n_wr_q;
   assign o_addr           = addr_q;
   assign o_wdata          = wdata_q;
   assign o_busy           = busy_q;
   assign o_done           = done_q;
   assign o_pass           = pass_q;
   assign o_err_cnt        = err_q;
   assign o_first_err_addr = first_q;
   assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_x_bist_seq.sv
// Self-checking bench for x_bist_seq: the bench plays the selected SRAM device
// and predicts results from the returned data at transaction level.
module tb_x_bist_seq;

   localparam int P_LAST = 3;
   localparam int P_TO   = 16;
   localparam int BUDGET = 400;

   logic         i_clk;
   logic         i_rst;
   logic         i_start;
   logic [3:0]   i_sel;
   logic [7:0]   i_seed;
   logic         i_abort;
   logic [15:0]  o_valid;
   logic [15:0]  i_accept;
   logic [15:0]  i_ready;
   logic [127:0] i_rdata;
   logic         o_rd_n_wr;
   logic [15:0]  o_addr;
   logic [7:0]   o_wdata;
   logic         o_busy;
   logic         o_done;
   logic         o_pass;
   logic [15:0]  o_err_cnt;
   logic [15:0]  o_first_err_addr;
   logic         o_timeout;

   int nChecks = 0;
   int nFail   = 0;

   x_bist_seq #(.p_last(16'd3), .p_timeout(P_TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_sel(i_sel),
      .i_seed(i_seed), .i_abort(i_abort), .o_valid(o_valid),
      .i_accept(i_accept), .i_ready(i_ready), .i_rdata(i_rdata),
      .o_rd_n_wr(o_rd_n_wr), .o_addr(o_addr), .o_wdata(o_wdata),
      .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
      .o_err_cnt(o_err_cnt), .o_first_err_addr(o_first_err_addr),
      .o_timeout(o_timeout)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [3:0]  sel;
      logic [7:0]  seed;
      logic [3:0]  badMask;
      logic [31:0] badVal;
      logic [15:0] expErr;
      logic [15:0] expFirst;
      logic        expPass;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drives one complete run as the selected device. Returned data per address
   // is the written byte unless badMask overrides it with a byte of badVal.
   task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] seed,
                                input logic [3:0] badMask, input logic [31:0] badVal,
                                input int accMin, input int accMax,
                                input int rdyMin, input int rdyMax,
                                input int stallAddr, input int abortAddr, input bit noise,
                                output int errs, output logic [15:0] first,
                                output int rdCnt, output int lat);
      logic [15:0] mask;
      logic [7:0]  mem [4];
      logic [7:0]  data;
      int          wrCnt, accCd, rdyCd, expNext, accCyc, cyc;
      bit          pend, rwait, deliver, seqOk, protoOk, timingOk, abortFire, abortSent;
      logic        rqRw;
      logic [15:0] rqAddr, rqValid, rdAddr;
      logic [7:0]  rqWd;

      mask = 16'd1 << sel;
      foreach (mem[k]) mem[k] = 8'h00;
      wrCnt = 0; rdCnt = 0; errs = 0; first = 16'd0; lat = 0;
      accCd = 0; rdyCd = 0; expNext = 0; accCyc = 0;
      pend = 0; rwait = 0; seqOk = 1; protoOk = 1; timingOk = 1;
      abortFire = 0; abortSent = 0;
      rqRw = 0; rqAddr = 0; rqValid = 0; rqWd = 0; rdAddr = 0;

      @(negedge i_clk);
      i_start = 1'b1; i_sel = sel; i_seed = seed;
      @(negedge i_clk);
      i_start = 1'b0;
      checkOutput("first valid", 32'(o_valid), 32'(mask));
      checkOutput("first addr", 32'(o_addr), 32'd0);
      checkOutput("first wdata", 32'(o_wdata), 32'(seed));
      checkOutput("first done cleared", 32'(o_done), 32'd0);

      for (cyc = 0; cyc < BUDGET; cyc++) begin
         i_accept = noise ? (16'($urandom) & ~mask) : 16'd0;
         i_ready  = noise ? (16'($urandom) & ~mask) : 16'd0;
         i_rdata  = {$urandom, $urandom, $urandom, $urandom};
         i_abort  = 1'b0;
         i_start  = 1'b0;

         case (expNext)
            1: if (o_valid != mask) timingOk = 0;
            2: if (o_valid != 16'd0 || !o_busy) timingOk = 0;
            3: if (!o_done || o_busy) timingOk = 0;
            4: if (o_busy || o_done || o_valid != 16'd0) timingOk = 0;
            default: ;
         endcase
         if (expNext == 0 && !o_busy) timingOk = 0;
         if (!o_busy) begin
            lat = cyc - accCyc;
            break;
         end
         expNext = 0;
         if ((o_valid & ~mask) != 16'd0) protoOk = 0;

         if (noise && $urandom_range(0, 15) == 0) begin
            i_start = 1'b1; i_sel = 4'($urandom); i_seed = 8'($urandom);
         end

         if (pend) begin
            if (o_valid != rqValid || o_rd_n_wr != rqRw || o_addr != rqAddr || o_wdata != rqWd)
               protoOk = 0;
         end else if (o_valid[sel]) begin
            pend = 1; rqValid = o_valid; rqRw = o_rd_n_wr; rqAddr = o_addr; rqWd = o_wdata;
            accCd = $urandom_range(accMin, accMax);
         end

         deliver = 0;
         if (pend) begin
            if (accCd == 0) begin
               i_accept[sel] = 1'b1;
               pend = 0;
               if (!rqRw) begin
                  if (rqAddr != 16'(wrCnt) || rqWd != (seed ^ wrCnt[7:0]) || rdCnt != 0) seqOk = 0;
                  mem[rqAddr[1:0]] = rqWd;
                  wrCnt++;
                  expNext = 1;
               end else begin
                  if (rqAddr != 16'(rdCnt) || wrCnt != P_LAST + 1) seqOk = 0;
                  rdAddr = rqAddr;
                  rdCnt++;
                  rdyCd = (int'(rqAddr) == stallAddr) ? -1 : $urandom_range(rdyMin, rdyMax);
                  if (int'(rqAddr) == abortAddr) abortFire = 1;
                  accCyc = cyc;
                  if (rdyCd == 0) deliver = 1;
                  else rwait = 1;
               end
            end else begin
               accCd--;
            end
         end else if (rwait) begin
            if (abortFire && !abortSent) begin
               i_abort = 1'b1;
               abortSent = 1;
            end
            if (rdyCd > 0) begin
               rdyCd--;
               if (rdyCd == 0) deliver = 1;
            end
         end

         if (deliver) begin
            data = badMask[rdAddr[1:0]] ? badVal[8*int'(rdAddr[1:0]) +: 8] : mem[rdAddr[1:0]];
            i_ready[sel] = 1'b1;
            i_rdata[{sel, 3'b000} +: 8] = data;
            if (data != (seed ^ rdAddr[7:0])) begin
               if (errs == 0) first = rdAddr;
               errs++;
            end
            rwait = 0;
            expNext = abortSent ? 4 : ((int'(rdAddr) == P_LAST) ? 3 : 1);
         end else if (rwait) begin
            expNext = (rdyCd < 0 && cyc - accCyc == P_TO) ? 3 : 2;
         end

         @(negedge i_clk);
      end

      i_accept = 16'd0; i_ready = 16'd0; i_start = 1'b0; i_abort = 1'b0;
      checkOutput("run ended in budget", 32'(cyc < BUDGET), 32'd1);
      checkOutput("write count", 32'(wrCnt), 32'(P_LAST + 1));
      checkOutput("request order", 32'(seqOk), 32'd1);
      checkOutput("handshake stability", 32'(protoOk), 32'd1);
      checkOutput("cycle timing", 32'(timingOk), 32'd1);
   endtask

   vec_t        vecs [5];
   int          errs, rdCnt, lat;
   logic [15:0] first;
   logic [3:0]  rSel, rMask;
   logic [7:0]  rSeed;
   logic [31:0] rVal;

   initial begin
      i_rst = 1'b0; i_start = 1'b0; i_sel = 4'd0; i_seed = 8'd0; i_abort = 1'b0;
      i_accept = 16'd0; i_ready = 16'd0; i_rdata = '0;
      #2 i_rst = 1'b1;
      #1;
      checkOutput("reset valid", 32'(o_valid), 32'd0);
      checkOutput("reset busy/done/pass/timeout", 32'({o_busy, o_done, o_pass, o_timeout}), 32'd0);
      checkOutput("reset err/first", {o_err_cnt, o_first_err_addr}, 32'd0);
      checkOutput("reset addr/wdata/rd", 32'({o_addr, o_wdata, o_rd_n_wr}), 32'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;

      vecs[0] = '{4'd2,  8'hA5, 4'b0000, 32'h0000_0000, 16'd0, 16'd0, 1'b1};
      vecs[1] = '{4'd2,  8'hA5, 4'b1100, 32'hFF00_0000, 16'd2, 16'd2, 1'b0};
      vecs[2] = '{4'd15, 8'h3C, 4'b0001, 32'h0000_0000, 16'd1, 16'd0, 1'b0};
      vecs[3] = '{4'd0,  8'h00, 4'b1010, 32'h5500_5500, 16'd2, 16'd1, 1'b0};
      vecs[4] = '{4'd7,  8'hFF, 4'b0100, 32'h00FD_0000, 16'd0, 16'd0, 1'b1};

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].sel, vecs[i].seed, vecs[i].badMask, vecs[i].badVal,
                       0, 3, 0, 3, -1, -1, 1'b1, errs, first, rdCnt, lat);
         checkOutput($sformatf("vec%0d err_cnt", i), 32'(o_err_cnt), 32'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d first_err_addr", i), 32'(o_first_err_addr), 32'(vecs[i].expFirst));
         checkOutput($sformatf("vec%0d pass", i), 32'(o_pass), 32'(vecs[i].expPass));
         checkOutput($sformatf("vec%0d done/timeout", i), 32'({o_done, o_timeout}), 32'b10);
      end

      for (int i = 0; i < 6; i++) begin
         rSel = 4'($urandom); rSeed = 8'($urandom); rMask = 4'($urandom); rVal = $urandom;
         applyStimulus(rSel, rSeed, rMask, rVal, 0, 4, 0, 4, -1, -1, 1'b1, errs, first, rdCnt, lat);
         checkOutput($sformatf("rnd%0d err_cnt", i), 32'(o_err_cnt), 32'(errs));
         checkOutput($sformatf("rnd%0d first_err_addr", i), 32'(o_first_err_addr), 32'(first));
         checkOutput($sformatf("rnd%0d pass", i), 32'(o_pass), 32'(errs == 0));
         checkOutput($sformatf("rnd%0d done", i), 32'(o_done), 32'd1);
      end

      // Accept held off 5 cycles everywhere; every read gets ready with accept.
      applyStimulus(4'd9, 8'h5A, 4'b0000, 32'h0, 5, 5, 0, 0, -1, -1, 1'b0, errs, first, rdCnt, lat);
      checkOutput("hold5 pass", 32'({o_done, o_pass}), 32'b11);

      // Read of addr 1 never gets ready.
      applyStimulus(4'd2, 8'hA5, 4'b0000, 32'h0, 0, 2, 1, 3, 1, -1, 1'b1, errs, first, rdCnt, lat);
      checkOutput("timeout latency", 32'(lat), 32'(P_TO + 1));
      checkOutput("timeout flag", 32'(o_timeout), 32'd1);
      checkOutput("timeout done/pass", 32'({o_done, o_pass}), 32'b10);
      checkOutput("timeout read count", 32'(rdCnt), 32'd2);
      repeat (5) @(negedge i_clk);
      checkOutput("no request after timeout", 32'(o_valid), 32'd0);

      // Abort raised while waiting for ready on addr 1.
      applyStimulus(4'd5, 8'h11, 4'b0000, 32'h0, 0, 2, 3, 3, -1, 1, 1'b0, errs, first, rdCnt, lat);
      checkOutput("abort done/busy", 32'({o_done, o_busy}), 32'b00);
      checkOutput("abort read count", 32'(rdCnt), 32'd2);
      repeat (3) @(negedge i_clk);
      checkOutput("abort stays idle", 32'({o_busy, o_valid}), 32'd0);

      // Asynchronous reset in the middle of a write.
      @(negedge i_clk);
      i_start = 1'b1; i_sel = 4'd3; i_seed = 8'h77; i_accept = 16'd0;
      @(negedge i_clk);
      i_start = 1'b0;
      @(negedge i_clk);
      checkOutput("pre-reset valid", 32'(o_valid), 32'h0008);
      i_rst = 1'b1;
      #1;
      checkOutput("async reset valid", 32'(o_valid), 32'd0);
      checkOutput("async reset wdata", 32'(o_wdata), 32'd0);
      checkOutput("async reset busy", 32'(o_busy), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
